// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// Data width and default receive FIFO sizing.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int RX_FIFO_DEPTH_LOG2_DEFAULT = 4;
endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage array.
// Synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int AW = RX_FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Store the incoming byte at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: frame-end edge detect, pointers, flags.
// Head byte is presented first-word-fall-through.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_int,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int AW = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic          rx_int_d;
  logic          wr_pulse;
  logic          rd_ok;
  logic          wr_ok;
  logic          drop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign wr_pulse = rx_int_d & ~rx_int;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign rd_ok    = rd_en & ~empty;
  assign wr_ok    = wr_pulse & (~full | rd_ok);
  assign drop     = wr_pulse & full & ~rd_ok;

  // Delay rx_int to find the end-of-frame falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_d <= 1'b0;
    end else begin
      rx_int_d <= rx_int;
    end
  end

  // Advance pointers on accepted writes and reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Track occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a new drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Inputs change and outputs are sampled 1ns after clk rises.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int n_cmp;
  int n_err;

  uart_rx_fifo #(
    .DEPTH_LOG2 (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_int   (rx_int),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [7:0] b,
                       input logic rd,
                       input logic clr);
    rx_data = b;
    rx_int  = 1'b1;
    tick();
    rx_int  = 1'b0;
    rd_en   = rd;
    ovf_clr = clr;
    tick();
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic pop(input logic [7:0] exp);
    chk("pop_data", 16'(rd_data), 16'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_int  = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    rst_n = 1'b1;
    tick();

    // three frames then drain
    frame(8'h55, 1'b0, 1'b0);
    chk("cnt1", 16'(count), 16'd1);
    chk("ne1", 16'(empty), 16'd0);
    frame(8'hA3, 1'b0, 1'b0);
    chk("cnt2", 16'(count), 16'd2);
    frame(8'h0F, 1'b0, 1'b0);
    chk("cnt3", 16'(count), 16'd3);
    chk("head55", 16'(rd_data), 16'h55);
    pop(8'h55);
    pop(8'hA3);
    pop(8'h0F);
    chk("drain_empty", 16'(empty), 16'd1);
    chk("drain_cnt", 16'(count), 16'd0);

    // fill to full, then drop one
    for (int i = 0; i < 16; i++) begin
      frame(8'(i), 1'b0, 1'b0);
    end
    chk("fill_full", 16'(full), 16'd1);
    chk("fill_cnt", 16'(count), 16'd16);
    chk("fill_ovf", 16'(overflow), 16'd0);
    frame(8'hFF, 1'b0, 1'b0);
    chk("drop_ovf", 16'(overflow), 16'd1);
    chk("drop_cnt", 16'(count), 16'd16);

    // clear coincident with another drop
    frame(8'hEE, 1'b0, 1'b1);
    chk("clr_race_ovf", 16'(overflow), 16'd1);
    chk("clr_race_cnt", 16'(count), 16'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_ovf", 16'(overflow), 16'd0);

    // full with coincident pop and push
    chk("head00", 16'(rd_data), 16'h00);
    frame(8'h77, 1'b1, 1'b0);
    chk("fullrw_cnt", 16'(count), 16'd16);
    chk("fullrw_ovf", 16'(overflow), 16'd0);
    for (int i = 1; i < 16; i++) begin
      pop(8'(i));
    end
    pop(8'h77);
    chk("fullrw_empty", 16'(empty), 16'd1);

    // empty with coincident pop and push
    frame(8'h3C, 1'b1, 1'b0);
    chk("emptyrw_cnt", 16'(count), 16'd1);
    chk("emptyrw_data", 16'(rd_data), 16'h3C);
    pop(8'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("under_cnt", 16'(count), 16'd0);
    chk("under_empty", 16'(empty), 16'd1);
    frame(8'h5A, 1'b0, 1'b0);
    chk("under_head", 16'(rd_data), 16'h5A);
    pop(8'h5A);

    // pointer wrap with steady traffic
    frame(8'hC0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      chk("wrap_head", 16'(rd_data), 16'(8'hC0 + i - 1));
      frame(8'(8'hC0 + i), 1'b1, 1'b0);
      chk("wrap_cnt", 16'(count), 16'd1);
    end
    pop(8'hD3);
    chk("wrap_empty", 16'(empty), 16'd1);

    // reset mid-frame with entries held
    for (int i = 0; i < 5; i++) begin
      frame(8'(8'h10 + i), 1'b0, 1'b0);
    end
    chk("pre_rst_cnt", 16'(count), 16'd5);
    rx_int = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 16'(count), 16'd0);
    chk("arst_empty", 16'(empty), 16'd1);
    tick();
    rx_int = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rel_cnt", 16'(count), 16'd0);
    chk("rel_empty", 16'(empty), 16'd1);
    frame(8'h99, 1'b0, 1'b0);
    chk("post_cnt", 16'(count), 16'd1);
    chk("post_head", 16'(rd_data), 16'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries.
REQ-002 clk  input  1  system clock (50 MHz), all logic on rising edge.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 rx_data  input  8  byte from UART receiver; stable from rx_int falling edge until the next frame completes.
REQ-005 rx_int  input  1  receiver busy flag; high during a frame, its falling edge marks rx_data valid.
REQ-006 rd_en  input  1  consumer pop request, one entry per high cycle.
REQ-007 rd_data  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-008 empty  output  1  FIFO holds zero entries.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 count  output  DEPTH_LOG2+1  number of entries held.
REQ-011 overflow  output  1  sticky flag: at least one byte dropped.
REQ-012 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-013 The block SHALL register rx_int once (rx_int_d) and generate wr_pulse = rx_int_d AND NOT rx_int, one clk cycle wide per frame.
REQ-014 On wr_pulse with FIFO not full, rx_data SHALL be written at wr_ptr; entry visible (count, empty) on the following cycle.
REQ-015 rd_data SHALL combinationally present mem[rd_ptr] whenever empty=0; value is don't-care when empty=1.
REQ-016 rd_en with empty=0 SHALL advance rd_ptr and decrement count at the next edge; rd_en with empty=1 SHALL be ignored, no pointer or count change.
REQ-017 wr_pulse and accepted rd_en in the same cycle SHALL both occur; count unchanged.
REQ-018 wr_pulse while full with accepted rd_en in the same cycle SHALL write (no drop, overflow unchanged).
REQ-019 wr_pulse while full without rd_en SHALL drop the byte, leave memory/pointers/count unchanged, and set overflow next cycle.
REQ-020 wr_pulse and rd_en while empty: write SHALL occur, read ignored; count becomes 1.
REQ-021 overflow SHALL stay high until ovf_clr=1; if set condition and ovf_clr coincide, set SHALL win.
REQ-022 wr_ptr and rd_ptr SHALL be DEPTH_LOG2 bits and wrap modulo DEPTH; full/empty SHALL derive from count (count==DEPTH / count==0).
REQ-023 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-024 On rst_n low: rx_int_d=0, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0; memory contents not reset.
REQ-025 Reset asserted mid-frame SHALL discard pending state; rx_int_d=0 guarantees no spurious wr_pulse on release even if rx_int is high.

Structure
REQ-026 Shared package uart_pkg SHALL hold UART_DATA_W=8 and RX_FIFO_DEPTH_LOG2_DEFAULT=4.
REQ-027 Storage SHALL be a sub-module uart_fifo_mem (sync write, async read, DEPTH x 8); pointers, count, flags and edge detect stay in uart_rx_fifo.
REQ-028 Target size 120-250 RTL lines total; no latches, single clock domain.

Verification
REQ-029 Reset then three frames 0x55, 0xA3, 0x0F (rx_int pulses) -> count 1,2,3 one cycle after each fall; rd_data=0x55; three rd_en pops yield 0x55, 0xA3, 0x0F, then empty=1.
REQ-030 Fill 16 frames 0x00..0x0F, 17th frame 0xFF, no reads -> full=1, overflow=1, count=16; pops return 0x00..0x0F, 0xFF never appears.
REQ-031 Full FIFO, wr_pulse (0x77) coincident with rd_en -> count stays 16, overflow stays 0, last popped byte is 0x77.
REQ-032 Empty FIFO, rd_en coincident with wr_pulse (0x3C) -> count=1, rd_data=0x3C, no underflow; rd_en alone while empty -> no change.
REQ-033 overflow=1, ovf_clr pulsed same cycle as another dropped write -> overflow stays 1; ovf_clr alone next -> overflow=0.
REQ-034 20 write/read cycles wrapping pointers past 15 -> data order preserved; rst_n asserted with rx_int high and 5 entries -> count=0, empty=1, no write on release until next rx_int fall.
